// File: rtl/dma_mem_cpu_cpu_ocimem_sequencer_if.sv
// rtl/dma_mem_cpu_cpu_ocimem_sequencer_if.sv - JTAG command strobes, Avalon-MM master bus and monitor results
interface dma_mem_cpu_cpu_ocimem_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [31:0]       m_writedata;
    logic [31:0]       m_readdata;
    logic              m_waitrequest;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    // Sequencer side: consumes strobes and read data, drives the bus and monitor results.
    modport master (
        input  jdo,
        input  take_action_ocimem_a,
        input  take_no_action_ocimem_a,
        input  take_action_ocimem_b,
        input  m_readdata,
        input  m_waitrequest,
        output m_address,
        output m_read,
        output m_write,
        output m_writedata,
        output MonDReg,
        output monitor_ready,
        output monitor_error
    );

    // Environment side: debug wrapper plus debug RAM.
    modport slave (
        output jdo,
        output take_action_ocimem_a,
        output take_no_action_ocimem_a,
        output take_action_ocimem_b,
        output m_readdata,
        output m_waitrequest,
        input  m_address,
        input  m_read,
        input  m_write,
        input  m_writedata,
        input  MonDReg,
        input  monitor_ready,
        input  monitor_error
    );
endinterface

// File: rtl/dma_mem_cpu_cpu_ocimem_sequencer.sv
// rtl/dma_mem_cpu_cpu_ocimem_sequencer.sv - turns JTAG monitor-memory commands into single Avalon-MM accesses
module dma_mem_cpu_cpu_ocimem_sequencer #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    dma_mem_cpu_cpu_ocimem_sequencer_if.master      bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       mon_d_reg;
    logic [31:0]       wdata;
    logic              rd_req;
    logic              wr_req;
    logic              ready;
    logic              error;
    logic [CNT_W-1:0]  cnt;

    logic [ADDR_W-1:0] addr_field;
    logic              rd_flag;
    logic [31:0]       wr_data;
    logic              any_strobe;
    logic              unused_jdo_bits;

    assign addr_field      = bus.jdo[17 +: ADDR_W];
    assign rd_flag         = bus.jdo[34];
    assign wr_data         = bus.jdo[34:3];
    assign any_strobe      = bus.take_action_ocimem_a | bus.take_no_action_ocimem_a
                           | bus.take_action_ocimem_b;
    assign unused_jdo_bits = ^{bus.jdo[37:35], bus.jdo[2:0]};

    // Command sequencer: accepts one command in IDLE, then owns the bus until the
    // access completes or the stall timeout gives up on it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr      <= '0;
            mon_d_reg <= '0;
            wdata     <= '0;
            rd_req    <= 1'b0;
            wr_req    <= 1'b0;
            ready     <= 1'b1;
            error     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.take_action_ocimem_b) begin
                        wdata  <= wr_data;
                        wr_req <= 1'b1;
                        ready  <= 1'b0;
                        error  <= 1'b0;
                        cnt    <= '0;
                        state  <= WR;
                    end else if (bus.take_action_ocimem_a) begin
                        addr <= addr_field;
                        if (rd_flag) begin
                            rd_req <= 1'b1;
                            ready  <= 1'b0;
                            error  <= 1'b0;
                            cnt    <= '0;
                            state  <= RD;
                        end
                    end else if (bus.take_no_action_ocimem_a) begin
                        rd_req <= 1'b1;
                        ready  <= 1'b0;
                        error  <= 1'b0;
                        cnt    <= '0;
                        state  <= RD;
                    end
                end
                RD, WR: begin
                    // A command arriving while busy is dropped and flagged.
                    if (any_strobe) begin
                        error <= 1'b1;
                    end
                    if (!bus.m_waitrequest) begin
                        if (state == RD) begin
                            mon_d_reg <= bus.m_readdata;
                        end
                        addr   <= addr + ADDR_W'(1);
                        rd_req <= 1'b0;
                        wr_req <= 1'b0;
                        ready  <= 1'b1;
                        state  <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        // Slave never answered: abandon the access, leave address and data alone.
                        rd_req <= 1'b0;
                        wr_req <= 1'b0;
                        ready  <= 1'b1;
                        error  <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    rd_req <= 1'b0;
                    wr_req <= 1'b0;
                    ready  <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.m_address     = addr;
    assign bus.m_read        = rd_req;
    assign bus.m_write       = wr_req;
    assign bus.m_writedata   = wdata;
    assign bus.MonDReg       = mon_d_reg;
    assign bus.monitor_ready = ready;
    assign bus.monitor_error = error;
endmodule

// File: tb/tb_dma_mem_cpu_cpu_ocimem_sequencer.sv
// tb/tb_dma_mem_cpu_cpu_ocimem_sequencer.sv - randomized self-checking bench with transaction-level model
module tb_dma_mem_cpu_cpu_ocimem_sequencer;
    localparam int AW = 8;
    localparam int T  = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dma_mem_cpu_cpu_ocimem_sequencer_if #(.ADDR_W(AW)) bus();

    dma_mem_cpu_cpu_ocimem_sequencer #(.ADDR_W(AW), .TIMEOUT_CYCLES(T)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] ram    [256];
    logic [31:0] shadow [256];

    logic        exp_read, exp_write, exp_ready, exp_error;
    logic [7:0]  exp_addr;
    logic [31:0] exp_wdata, exp_mon;
    logic [7:0]  m_addr;
    bit          check_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    assign bus.m_readdata = ram[bus.m_address];

    always @(posedge clk) begin
        if (bus.m_write && !bus.m_waitrequest) ram[bus.m_address] <= bus.m_writedata;
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("m_read",        32'(bus.m_read),        32'(exp_read));
            chk("m_write",       32'(bus.m_write),       32'(exp_write));
            chk("m_address",     32'(bus.m_address),     32'(exp_addr));
            chk("m_writedata",   bus.m_writedata,        exp_wdata);
            chk("MonDReg",       bus.MonDReg,            exp_mon);
            chk("monitor_ready", 32'(bus.monitor_ready), 32'(exp_ready));
            chk("monitor_error", 32'(bus.monitor_error), 32'(exp_error));
            chk("rw_exclusive",  32'(bus.m_read & bus.m_write), 32'd0);
        end
    end

    task automatic clear_strobes();
        bus.take_action_ocimem_a    = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b    = 1'b0;
    endtask

    task automatic fire_strobe(input int kind);
        case (kind)
            0:       bus.take_action_ocimem_a    = 1'b1;
            1:       bus.take_no_action_ocimem_a = 1'b1;
            default: bus.take_action_ocimem_b    = 1'b1;
        endcase
    endtask

    function automatic logic [37:0] rnd_jdo();
        return {6'($urandom), $urandom};
    endfunction

    task automatic model_reset();
        m_addr    = 8'h00;
        exp_addr  = 8'h00;
        exp_read  = 1'b0;
        exp_write = 1'b0;
        exp_ready = 1'b1;
        exp_error = 1'b0;
        exp_wdata = 32'h0;
        exp_mon   = 32'h0;
    endtask

    // kind: 0 = action_ocimem_a, 1 = no_action_ocimem_a, 2 = ocimem_b
    // stalls >= T means the slave never responds within the timeout window.
    task automatic cmd(input int kind, input logic [7:0] ja, input bit rd,
                       input logic [31:0] wd, input int stalls, input bit collide);
        logic [37:0] j;
        int n;
        j = rnd_jdo();
        if (kind == 2) begin
            j[34:3] = wd;
        end else if (kind == 0) begin
            j[24:17] = ja;
            j[34]    = rd;
        end
        bus.jdo = j;
        fire_strobe(kind);
        @(posedge clk); #1;
        clear_strobes();
        bus.jdo = rnd_jdo();
        if (kind == 0) begin
            m_addr   = ja;
            exp_addr = ja;
            if (!rd) return;
        end
        if (kind == 2) exp_wdata = wd;
        exp_read  = (kind != 2);
        exp_write = (kind == 2);
        exp_ready = 1'b0;
        exp_error = 1'b0;
        n = (stalls >= T) ? T : stalls + 1;
        for (int i = 0; i < n; i++) begin
            bus.m_waitrequest = (i < stalls);
            if (collide && i == 0) begin
                bus.jdo = rnd_jdo();
                fire_strobe(int'($urandom_range(0, 2)));
            end
            if (collide && i > 0) exp_error = 1'b1;
            @(posedge clk); #1;
            clear_strobes();
        end
        bus.m_waitrequest = 1'b0;
        exp_read  = 1'b0;
        exp_write = 1'b0;
        exp_ready = 1'b1;
        if (stalls >= T) begin
            exp_error = 1'b1;
        end else begin
            exp_error = collide;
            if (kind == 2) begin
                shadow[m_addr] = wd;
            end else begin
                exp_mon = shadow[m_addr];
            end
            m_addr   = m_addr + 8'd1;
            exp_addr = m_addr;
        end
    endtask

    initial begin
        clear_strobes();
        bus.jdo           = '0;
        bus.m_waitrequest = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram[i]    = $urandom;
            shadow[i] = ram[i];
        end
        ram[8'h10] = 32'hDEADBEEF; shadow[8'h10] = 32'hDEADBEEF;
        ram[8'hFF] = 32'hA5A50FF0; shadow[8'hFF] = 32'hA5A50FF0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_read",  32'(bus.m_read),        32'd0);
        chk("rst_m_write", 32'(bus.m_write),       32'd0);
        chk("rst_ready",   32'(bus.monitor_ready), 32'd1);
        chk("rst_error",   32'(bus.monitor_error), 32'd0);
        chk("rst_mon",     bus.MonDReg,            32'h0);
        chk("rst_addr",    32'(bus.m_address),     32'h0);
        reset_n  = 1'b1;
        check_en = 1'b1;
        @(posedge clk); #1;

        // Load + read
        cmd(0, 8'h10, 1'b1, 32'h0, 0, 1'b0);
        chk("t1_mon",   bus.MonDReg,            32'hDEADBEEF);
        chk("t1_addr",  32'(bus.m_address),     32'h11);
        chk("t1_ready", 32'(bus.monitor_ready), 32'd1);

        // Stalled write then read-back
        cmd(2, 8'h00, 1'b0, 32'h12345678, 3, 1'b0);
        chk("t2_addr", 32'(bus.m_address), 32'h12);
        cmd(0, 8'h11, 1'b1, 32'h0, 0, 1'b0);
        chk("t2_mon", bus.MonDReg, 32'h12345678);

        // Address wrap
        cmd(0, 8'hFF, 1'b0, 32'h0, 0, 1'b0);
        cmd(1, 8'h00, 1'b0, 32'h0, 0, 1'b0);
        chk("t3_addr", 32'(bus.m_address), 32'h00);
        chk("t3_mon",  bus.MonDReg,        32'hA5A50FF0);

        // Timeout, then a good read clears the error
        cmd(1, 8'h00, 1'b0, 32'h0, 6, 1'b0);
        chk("t4_error", 32'(bus.monitor_error), 32'd1);
        chk("t4_ready", 32'(bus.monitor_ready), 32'd1);
        chk("t4_mon",   bus.MonDReg,            32'hA5A50FF0);
        chk("t4_addr",  32'(bus.m_address),     32'h00);
        cmd(1, 8'h00, 1'b0, 32'h0, 0, 1'b0);
        chk("t4_clear", 32'(bus.monitor_error), 32'd0);
        chk("t4_addr2", 32'(bus.m_address),     32'h01);

        // Busy collision during a stalled read
        cmd(1, 8'h00, 1'b0, 32'h0, 2, 1'b1);
        chk("t5_error", 32'(bus.monitor_error), 32'd1);
        chk("t5_addr",  32'(bus.m_address),     32'h02);

        // Randomized command stream
        for (int k = 0; k < 200; k++) begin
            cmd(int'($urandom_range(0, 2)), 8'($urandom), 1'($urandom),
                $urandom, int'($urandom_range(0, 5)), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        // Reset during a stalled read
        bus.jdo = rnd_jdo();
        fire_strobe(1);
        @(posedge clk); #1;
        clear_strobes();
        bus.m_waitrequest = 1'b1;
        exp_read  = 1'b1;
        exp_ready = 1'b0;
        exp_error = 1'b0;
        @(posedge clk); #1;
        check_en = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("t6_m_read", 32'(bus.m_read),        32'd0);
        chk("t6_ready",  32'(bus.monitor_ready), 32'd1);
        chk("t6_error",  32'(bus.monitor_error), 32'd0);
        chk("t6_mon",    bus.MonDReg,            32'h0);
        chk("t6_addr",   32'(bus.m_address),     32'h0);
        chk("t6_wdata",  bus.m_writedata,        32'h0);
        bus.m_waitrequest = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset_n  = 1'b1;
        check_en = 1'b1;
        @(posedge clk); #1;
        cmd(1, 8'h00, 1'b0, 32'h0, 1, 1'b0);
        chk("t6_addr_after", 32'(bus.m_address), 32'h01);

        @(posedge clk); #1;
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
